crc_rx_engine: RTL and testbench
================================

CRC_RX_ENGINE -- requirements
Module: crc_rx_engine

Interface
REQ-001 The block SHALL have the parameter OVERSAMPLE, default 16, meaning tick_i rising edges per UART bit period.
REQ-002 The block SHALL have the port clk_i, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have the port rst_i, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-004 The block SHALL have the port rx_i, input, 1 bit: asynchronous UART serial line, idle high.
REQ-005 The block SHALL have the port rx_en_i, input, 1 bit: receive enable, active high.
REQ-006 The block SHALL have the port tick_i, input, 1 bit: oversample strobe, slower than clk_i; each rising edge is one sample event.
REQ-007 The block SHALL have the port out_o, output, 24 bits: payload of the last completed frame, first byte received in [23:16].
REQ-008 The block SHALL have the port error_o, output, 1 bit: CRC or framing error flag for the last completed frame.

Function
REQ-009 rx_i and tick_i SHALL each pass through a 2-flop synchronizer in clk_i.
REQ-010 A sample event SHALL be one clk_i cycle where synchronized tick_i is 1 and its previous value was 0.
REQ-011 Serial format SHALL be 8N1, LSB first: 1 start bit (0), 8 data bits, 1 stop bit (1).
REQ-012 The byte receiver FSM SHALL have the states IDLE, START, DATA, STOP.
REQ-013 IDLE -> START on synchronized rx = 0; the tick counter SHALL clear on this transition.
REQ-014 START: after OVERSAMPLE/2 sample events, if rx = 0 -> DATA with the counter cleared, else -> IDLE (false start, ignored).
REQ-015 DATA: every OVERSAMPLE sample events, rx SHALL be shifted in as the next bit (bit 0 first); after 8 bits -> STOP.
REQ-016 STOP: after OVERSAMPLE sample events, rx SHALL be sampled; a 0 sets the frame's sticky framing-error flag; the byte is delivered either way and the FSM returns to IDLE.
REQ-017 A frame SHALL be 5 consecutive bytes: P0, P1, P2 (payload), then C_hi, C_lo (CRC, high byte first).
REQ-018 The byte index (0..4) SHALL increment on each delivered byte and wrap to 0 after byte 4.
REQ-019 The CRC SHALL be CRC-16/XMODEM: poly 0x1021, init 0x0000, no reflection, no final XOR.
REQ-020 The CRC SHALL process each delivered byte MSB first.
REQ-021 The CRC SHALL run over all 5 bytes; a remainder of 0x0000 means the CRC is good.
REQ-022 Payload bytes SHALL be held in a 24-bit shift register, P0 landing in [23:16].
REQ-023 One clk_i cycle after the stop-bit sample of byte 4, out_o SHALL load {P0,P1,P2}.
REQ-024 In that same cycle, error_o SHALL load (remainder != 0) OR framing-error flag.
REQ-025 In that same cycle, the CRC register, byte index and framing flag SHALL re-initialize.
REQ-026 out_o and error_o SHALL hold their values until the next frame completes; they do not change mid-frame.
REQ-027 rx_en_i = 0 SHALL force the FSM to IDLE and clear the byte index, CRC register and framing flag (partial frame discarded) without changing out_o or error_o.
REQ-028 With rx_en_i = 0, rx_i activity SHALL be ignored.
REQ-029 Sample-event counting SHALL use only detected tick_i rising edges, never raw clk_i cycles.
REQ-030 Bytes may be separated by any idle gap (≥ 0 extra stop-bit time); there is no inter-byte timeout.

Reset
REQ-031 While rst_i = 0 at a clk_i edge, the block SHALL reset: FSM = IDLE, counters = 0, CRC = 0x0000, byte index = 0, framing flag = 0, out_o = 24'h000000, error_o = 0, synchronizer flops = 1 (rx) / 0 (tick).
REQ-032 Reset asserted mid-frame SHALL discard the partial frame; reception resumes with byte 0 on the first start bit after release.

Verification
REQ-033 Bytes 00 00 00 00 00 -> out_o = 000000, error_o = 0.
REQ-034 Bytes 00 00 01 10 21 -> out_o = 000001, error_o = 0 (CRC 0x1021).
REQ-035 Bytes 48 69 21 00 00 ("Hi!", wrong CRC) -> out_o = 486921, error_o = 1.
REQ-036 Bytes 00 00 01 10 21, with byte 2's stop bit driven 0 -> out_o = 000001, error_o = 1.
REQ-037 A 0.25-bit low glitch on rx_i, then bytes 00 00 01 10 21 -> glitch ignored; out_o = 000001, error_o = 0.
REQ-038 Two bytes, then rx_en_i = 0 for 1 bit time, then re-enable and send 00 00 01 10 21 -> out_o = 000001, error_o = 0; out_o and error_o unchanged during the abort.

Source files
------------

// File: rtl/crc_rx_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : crc_rx_engine
//  Description : Oversampled 8N1 UART receiver that assembles 5-byte frames
//                (3 payload bytes + CRC-16/XMODEM) and publishes the payload
//                together with a CRC/framing error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_rx_engine #(
   parameter int OVERSAMPLE = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        rx_i,
   input  logic        rx_en_i,
   input  logic        tick_i,
   output logic [23:0] out_o,
   output logic        error_o
);

   localparam int CW = $clog2(OVERSAMPLE) + 1;
   localparam logic [CW-1:0] c_ZERO    = '0;
   localparam logic [CW-1:0] c_ONE     = CW'(1);
   localparam logic [CW-1:0] c_HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] c_FULL_M1 = CW'(OVERSAMPLE - 1);
   localparam logic [15:0]   c_POLY    = 16'h1021;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // Synchronizers and tick edge history
   logic          r_rx_s1, r_rx_s2;
   logic          r_tick_s1, r_tick_s2, r_tick_d;

   // Byte receiver state
   state_t        r_state, w_state_next;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic [2:0]    r_bit, w_bit_next;
   logic [7:0]    r_shift, w_shift_next;
   logic          w_deliver;
   logic          w_stop_bad;

   // Frame assembly state
   logic [15:0]   r_crc, w_crc_next;
   logic [2:0]    r_idx;
   logic          r_ferr;
   logic          r_done;
   logic [23:0]   r_payload;
   logic [23:0]   r_out;
   logic          r_err;

   logic          w_rx;
   logic          w_sample;

   assign w_rx     = r_rx_s2;
   assign w_sample = r_tick_s2 & ~r_tick_d;
   assign out_o    = r_out;
   assign error_o  = r_err;

   // Two-flop synchronizers for the line and the tick, plus tick history for edge detect
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_tick_s1 <= 1'b0;
         r_tick_s2 <= 1'b0;
         r_tick_d  <= 1'b0;
      end else begin
         r_rx_s1   <= rx_i;
         r_rx_s2   <= r_rx_s1;
         r_tick_s1 <= tick_i;
         r_tick_s2 <= r_tick_s1;
         r_tick_d  <= r_tick_s2;
      end
   end

   // Byte receiver state register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= c_ZERO;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_bit   <= w_bit_next;
         r_shift <= w_shift_next;
      end
   end

   // Byte receiver next-state logic; all timing advances only on tick edges
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_bit_next   = r_bit;
      w_shift_next = r_shift;
      w_deliver    = 1'b0;
      w_stop_bad   = 1'b0;
      if (!rx_en_i) begin
         w_state_next = S_IDLE;
         w_cnt_next   = c_ZERO;
         w_bit_next   = 3'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_rx) begin
                  w_state_next = S_START;
                  w_cnt_next   = c_ZERO;
                  w_bit_next   = 3'd0;
               end
            end
            S_START: begin
               if (w_sample) begin
                  if (r_cnt == c_HALF_M1) begin
                     // Mid-start re-check rejects glitches shorter than half a bit
                     w_cnt_next   = c_ZERO;
                     w_state_next = w_rx ? S_IDLE : S_DATA;
                  end else begin
                     w_cnt_next = r_cnt + c_ONE;
                  end
               end
            end
            S_DATA: begin
               if (w_sample) begin
                  if (r_cnt == c_FULL_M1) begin
                     w_cnt_next   = c_ZERO;
                     w_shift_next = {w_rx, r_shift[7:1]};
                     w_bit_next   = r_bit + 3'd1;
                     if (r_bit == 3'd7) begin
                        w_state_next = S_STOP;
                     end
                  end else begin
                     w_cnt_next = r_cnt + c_ONE;
                  end
               end
            end
            S_STOP: begin
               if (w_sample) begin
                  if (r_cnt == c_FULL_M1) begin
                     w_cnt_next   = c_ZERO;
                     w_deliver    = 1'b1;
                     w_stop_bad   = ~w_rx;
                     w_state_next = S_IDLE;
                  end else begin
                     w_cnt_next = r_cnt + c_ONE;
                  end
               end
            end
            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   // CRC-16/XMODEM update of the running remainder with the completed byte, MSB first
   always_comb begin
      w_crc_next = r_crc ^ {r_shift, 8'h00};
      for (int i = 0; i < 8; i++) begin
         if (w_crc_next[15]) begin
            w_crc_next = {w_crc_next[14:0], 1'b0} ^ c_POLY;
         end else begin
            w_crc_next = {w_crc_next[14:0], 1'b0};
         end
      end
   end

   // Frame assembly: accumulate CRC and payload, publish results one cycle after byte 4
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         r_crc     <= 16'h0000;
         r_idx     <= 3'd0;
         r_ferr    <= 1'b0;
         r_done    <= 1'b0;
         r_payload <= 24'h000000;
         r_out     <= 24'h000000;
         r_err     <= 1'b0;
      end else if (!rx_en_i) begin
         r_crc  <= 16'h0000;
         r_idx  <= 3'd0;
         r_ferr <= 1'b0;
         r_done <= 1'b0;
      end else if (r_done) begin
         r_out  <= r_payload;
         r_err  <= (r_crc != 16'h0000) | r_ferr;
         r_crc  <= 16'h0000;
         r_idx  <= 3'd0;
         r_ferr <= 1'b0;
         r_done <= 1'b0;
      end else if (w_deliver) begin
         r_crc  <= w_crc_next;
         r_ferr <= r_ferr | w_stop_bad;
         if (r_idx < 3'd3) begin
            r_payload <= {r_payload[15:0], r_shift};
         end
         if (r_idx == 3'd4) begin
            r_done <= 1'b1;
         end else begin
            r_idx <= r_idx + 3'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_crc_rx_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_crc_rx_engine
//  Description : Scoreboard bench for crc_rx_engine; stimulus pushes expected
//                frame results, a monitor compares on every output change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_rx_engine;

   localparam int BIT_NS = 640;   // 16 ticks of 40 ns each

   logic        clk_i   = 1'b0;
   logic        rst_i   = 1'b0;
   logic        rx_i    = 1'b1;
   logic        rx_en_i = 1'b0;
   logic        tick_i  = 1'b0;
   logic [23:0] out_o;
   logic        error_o;

   typedef struct packed {
      logic [23:0] out;
      logic        err;
   } exp_t;

   exp_t        q[$];
   int          n_cmp  = 0;
   int          n_fail = 0;
   bit          mon_en = 1'b0;
   logic [24:0] prev   = 25'h0;

   crc_rx_engine #(.OVERSAMPLE(16)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .rx_i    (rx_i),
      .rx_en_i (rx_en_i),
      .tick_i  (tick_i),
      .out_o   (out_o),
      .error_o (error_o)
   );

   always #5  clk_i  = ~clk_i;
   always #20 tick_i = ~tick_i;

   // One 8N1 byte, LSB first, followed by one idle bit. A bad stop bit is held
   // low past its mid-bit sample and released early so the line is high again
   // before the receiver's half-bit start re-check.
   task automatic send_byte(input logic [7:0] b, input bit bad_stop);
      rx_i = 1'b0;
      #BIT_NS;
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         #BIT_NS;
      end
      if (bad_stop) begin
         rx_i = 1'b0;
         #(BIT_NS * 5 / 8);
         rx_i = 1'b1;
         #(BIT_NS * 3 / 8);
      end else begin
         rx_i = 1'b1;
         #BIT_NS;
      end
      rx_i = 1'b1;
      #BIT_NS;
   endtask

   task automatic send_frame(input logic [39:0] bytes, input int bad_idx,
                             input logic [23:0] e_out, input logic e_err);
      exp_t e;
      logic [7:0] b;
      e.out = e_out;
      e.err = e_err;
      q.push_back(e);
      for (int k = 0; k < 5; k++) begin
         b = bytes[39 - 8*k -: 8];
         send_byte(b, (k == bad_idx));
      end
      #(2 * BIT_NS);
   endtask

   // Monitor: every change of the published outputs consumes one expectation
   always @(negedge clk_i) begin
      exp_t e;
      if (mon_en && ({out_o, error_o} !== prev)) begin
         prev = {out_o, error_o};
         if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_change: out_o=%h error_o=%b, required no change", out_o, error_o);
         end else begin
            e = q.pop_front();
            n_cmp++;
            if (out_o !== e.out) begin
               n_fail++;
               $display("FAIL frame_out: out_o=%h, required %h", out_o, e.out);
            end
            n_cmp++;
            if (error_o !== e.err) begin
               n_fail++;
               $display("FAIL frame_err: error_o=%b, required %b (out %h)", error_o, e.err, e.out);
            end
         end
      end
   end

   initial begin
      repeat (5) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);

      n_cmp++;
      if (out_o !== 24'h000000) begin
         n_fail++;
         $display("FAIL reset_out: out_o=%h, required 000000", out_o);
      end
      n_cmp++;
      if (error_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_err: error_o=%b, required 0", error_o);
      end

      rx_en_i = 1'b1;
      mon_en  = 1'b1;
      repeat (4) @(negedge clk_i);

      // "Hi!" with a zero CRC field
      send_frame(40'h48_69_21_00_00, -1, 24'h486921, 1'b1);
      // Good CRC 0x1021 over 00 00 01
      send_frame(40'h00_00_01_10_21, -1, 24'h000001, 1'b0);
      // All zeros is a valid frame
      send_frame(40'h00_00_00_00_00, -1, 24'h000000, 1'b0);

      // Quarter-bit glitch must be rejected as a false start
      rx_i = 1'b0;
      #(BIT_NS / 4);
      rx_i = 1'b1;
      #BIT_NS;
      send_frame(40'h00_00_01_10_21, -1, 24'h000001, 1'b0);

      // Framing error on byte 2 with otherwise good CRC
      send_frame(40'h00_00_01_10_21, 2, 24'h000001, 1'b1);

      // Partial frame aborted by disable; outputs must not move during the abort
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      rx_en_i = 1'b0;
      #BIT_NS;
      rx_en_i = 1'b1;
      #BIT_NS;
      send_frame(40'h00_00_01_10_21, -1, 24'h000001, 1'b0);

      #(4 * BIT_NS);
      n_cmp++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_frames: %0d outstanding, required 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
